// File: rtl/doorlock_keypad_ctrl.sv
// Keypad-side sequencer for the door-lock comparator: captures a digit, commands a check,
// holds the door open, and locks out after repeated failures. Optional macro: DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN.
module doorlock_keypad_ctrl #(
  parameter int OPEN_CYCLES    = 16,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int ENTRY_TIMEOUT  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       door_open,
  output logic [1:0] state,
  output logic [3:0] ps_num,
  output logic [3:0] fail_cnt,
  output logic       locked_out
);

  localparam int OPEN_W = $clog2(OPEN_CYCLES) + 1;
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES) + 1;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_ENTRY = 2'b01;
  localparam logic [1:0] CMD_CHECK = 2'b10;
  localparam logic [1:0] CMD_LOCK  = 2'b11;

  if (MAX_FAIL < 1 || MAX_FAIL > 15 || OPEN_CYCLES < 1 ||
      LOCKOUT_CYCLES < 1 || ENTRY_TIMEOUT < 1) begin : g_bad_cfg
    $error("doorlock_keypad_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_LOCKOUT
  } fsm_t;

  fsm_t              fsm, fsm_nxt;
  logic [1:0]        state_nxt;
  logic [3:0]        ps_nxt;
  logic [3:0]        fail_nxt;
  logic [3:0]        fail_inc;
  logic              locked_nxt;
  logic [OPEN_W-1:0] hold_tmr, hold_nxt;
  logic [LOCK_W-1:0] lock_tmr, lock_nxt;
`ifdef DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN
  localparam int ENT_W = $clog2(ENTRY_TIMEOUT) + 1;
  logic [ENT_W-1:0]  ent_tmr, ent_nxt;
`endif

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'h1;
  endfunction

  // OPEN shares the CHECK code so the lock keeps its output enabled during the hold.
  function automatic logic [1:0] cmd_of(input fsm_t s);
    logic [1:0] c;
    case (s)
      S_ENTRY:   c = CMD_ENTRY;
      S_CHECK:   c = CMD_CHECK;
      S_OPEN:    c = CMD_CHECK;
      S_LOCKOUT: c = CMD_LOCK;
      default:   c = CMD_IDLE;
    endcase
    return c;
  endfunction

  assign fail_inc = sat_inc4(fail_cnt);

  always_comb begin
    fsm_nxt  = fsm;
    ps_nxt   = ps_num;
    fail_nxt = fail_cnt;
    hold_nxt = hold_tmr;
    lock_nxt = lock_tmr;
`ifdef DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN
    ent_nxt  = ent_tmr;
`endif
    case (fsm)
      S_IDLE: begin
        if (!key_clear && !key_enter && key_valid) begin
          ps_nxt  = key_code;
          fsm_nxt = S_ENTRY;
`ifdef DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN
          ent_nxt = '0;
`endif
        end
      end
      S_ENTRY: begin
        if (key_clear) begin
          ps_nxt  = 4'h0;
          fsm_nxt = S_IDLE;
        end else if (key_enter) begin
          fsm_nxt = S_CHECK;
        end else if (key_valid) begin
          ps_nxt  = key_code;
`ifdef DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN
          ent_nxt = '0;
`endif
        end else begin
`ifdef DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN
          if (ent_tmr == ENT_W'(ENTRY_TIMEOUT - 1)) begin
            ps_nxt  = 4'h0;
            ent_nxt = '0;
            fsm_nxt = S_IDLE;
          end else begin
            ent_nxt = ent_tmr + ENT_W'(1);
          end
`else
          fsm_nxt = S_ENTRY;
`endif
        end
      end
      S_CHECK: begin
        if (door_open) begin
          fail_nxt = 4'h0;
          hold_nxt = OPEN_W'(OPEN_CYCLES - 1);
          fsm_nxt  = S_OPEN;
        end else begin
          fail_nxt = fail_inc;
          ps_nxt   = 4'h0;
          if (fail_inc == 4'(MAX_FAIL)) begin
            lock_nxt = LOCK_W'(LOCKOUT_CYCLES - 1);
            fsm_nxt  = S_LOCKOUT;
          end else begin
            fsm_nxt  = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (hold_tmr == '0) begin
          ps_nxt  = 4'h0;
          fsm_nxt = S_IDLE;
        end else begin
          hold_nxt = hold_tmr - OPEN_W'(1);
        end
      end
      S_LOCKOUT: begin
        if (lock_tmr == '0) begin
          fail_nxt = 4'h0;
          fsm_nxt  = S_IDLE;
        end else begin
          lock_nxt = lock_tmr - LOCK_W'(1);
        end
      end
      default: begin
        ps_nxt  = 4'h0;
        fsm_nxt = S_IDLE;
      end
    endcase
    state_nxt  = cmd_of(fsm_nxt);
    locked_nxt = (fsm_nxt == S_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= S_IDLE;
      state      <= CMD_IDLE;
      ps_num     <= 4'h0;
      fail_cnt   <= 4'h0;
      locked_out <= 1'b0;
      hold_tmr   <= '0;
      lock_tmr   <= '0;
`ifdef DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN
      ent_tmr    <= '0;
`endif
    end else begin
      fsm        <= fsm_nxt;
      state      <= state_nxt;
      ps_num     <= ps_nxt;
      fail_cnt   <= fail_nxt;
      locked_out <= locked_nxt;
      hold_tmr   <= hold_nxt;
      lock_tmr   <= lock_nxt;
`ifdef DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN
      ent_tmr    <= ent_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_doorlock_keypad_ctrl.sv
// Bench for doorlock_keypad_ctrl: vector table plus hand-written corner sequences, scoreboard-checked.
module tb_doorlock_keypad_ctrl;
  localparam logic [3:0] SECRET = 4'hD;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid, key_enter, key_clear, door_open, door_force;
  logic [3:0] key_code;
  logic [1:0] state;
  logic [3:0] ps_num, fail_cnt;
  logic       locked_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic       ke;
    logic       kcl;
    logic [1:0] st;
    logic [3:0] ps;
    logic [3:0] fc;
    logic       lo;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [3:0] ps;
    logic [3:0] fc;
    logic       lo;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  // Model comparator: opens only on the secret digit while commanded to check.
  assign door_open = door_force | ((state == 2'b10) && (ps_num == SECRET));

  doorlock_keypad_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .door_open  (door_open),
    .state      (state),
    .ps_num     (ps_num),
    .fail_cnt   (fail_cnt),
    .locked_out (locked_out)
  );

  function automatic void add(input logic kv, input logic [3:0] kc, input logic ke, input logic kcl,
                              input logic [1:0] st, input logic [3:0] ps, input logic [3:0] fc,
                              input logic lo);
    vec_t v;
    v.kv = kv; v.kc = kc; v.ke = ke; v.kcl = kcl;
    v.st = st; v.ps = ps; v.fc = fc; v.lo = lo;
    tbl.push_back(v);
  endfunction

  function automatic void push_exp(input logic [1:0] st, input logic [3:0] ps,
                                   input logic [3:0] fc, input logic lo);
    exp_t e;
    e.st = st; e.ps = ps; e.fc = fc; e.lo = lo;
    sb.push_back(e);
  endfunction

  task automatic check(input string nm);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    if (state !== e.st || ps_num !== e.ps || fail_cnt !== e.fc || locked_out !== e.lo) begin
      bad++;
      $display("FAIL %s: got state=%b ps_num=%h fail_cnt=%0d locked_out=%b, want state=%b ps_num=%h fail_cnt=%0d locked_out=%b",
               nm, state, ps_num, fail_cnt, locked_out, e.st, e.ps, e.fc, e.lo);
    end
  endtask

  task automatic cyc(input logic kv, input logic [3:0] kc, input logic ke, input logic kcl,
                     input logic [1:0] st, input logic [3:0] ps, input logic [3:0] fc,
                     input logic lo, input string nm);
    key_valid = kv; key_code = kc; key_enter = ke; key_clear = kcl;
    push_exp(st, ps, fc, lo);
    @(posedge clk);
    #1;
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    check(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; key_enter = 1'b0; key_clear = 1'b0;
    door_force = 1'b0;

    // correct entry: 17 cycles at 10
    add(1, 4'hD, 0, 0, 2'b01, 4'hD, 0, 0);
    add(0, 4'h0, 1, 0, 2'b10, 4'hD, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 4'h0, 0, 0, 2'b10, 4'hD, 0, 0);
    add(0, 4'h0, 0, 0, 2'b00, 4'h0, 0, 0);
    // wrong entry
    add(1, 4'h3, 0, 0, 2'b01, 4'h3, 0, 0);
    add(0, 4'h0, 1, 0, 2'b10, 4'h3, 0, 0);
    add(0, 4'h0, 0, 0, 2'b00, 4'h0, 1, 0);
    // two more wrong -> lockout, keys ignored for 64 cycles
    add(1, 4'h3, 0, 0, 2'b01, 4'h3, 1, 0);
    add(0, 4'h0, 1, 0, 2'b10, 4'h3, 1, 0);
    add(0, 4'h0, 0, 0, 2'b00, 4'h0, 2, 0);
    add(1, 4'h3, 0, 0, 2'b01, 4'h3, 2, 0);
    add(0, 4'h0, 1, 0, 2'b10, 4'h3, 2, 0);
    add(0, 4'h0, 0, 0, 2'b11, 4'h0, 3, 1);
    for (int i = 0; i < 63; i++)
      add((i % 3) == 0, 4'hD, (i % 3) == 1, (i % 3) == 2, 2'b11, 4'h0, 3, 1);
    add(0, 4'h0, 0, 0, 2'b00, 4'h0, 0, 0);
    // overwrite: last digit wins
    add(1, 4'h5, 0, 0, 2'b01, 4'h5, 0, 0);
    add(1, 4'hD, 0, 0, 2'b01, 4'hD, 0, 0);
    add(0, 4'h0, 1, 0, 2'b10, 4'hD, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 4'h0, 0, 0, 2'b10, 4'hD, 0, 0);
    add(0, 4'h0, 0, 0, 2'b00, 4'h0, 0, 0);
    // clear, clear beats enter, idle ignores enter/clear
    add(1, 4'h5, 0, 0, 2'b01, 4'h5, 0, 0);
    add(0, 4'h0, 0, 1, 2'b00, 4'h0, 0, 0);
    add(1, 4'h5, 0, 0, 2'b01, 4'h5, 0, 0);
    add(0, 4'h0, 1, 1, 2'b00, 4'h0, 0, 0);
    add(0, 4'h0, 1, 0, 2'b00, 4'h0, 0, 0);
    add(0, 4'h0, 0, 1, 2'b00, 4'h0, 0, 0);
    // enter beats valid; valid during CHECK dropped
    add(1, 4'h7, 0, 0, 2'b01, 4'h7, 0, 0);
    add(1, 4'h5, 1, 0, 2'b10, 4'h7, 0, 0);
    add(1, 4'h9, 0, 0, 2'b00, 4'h0, 1, 0);
    // fail then success clears fail_cnt from 2
    add(1, 4'h3, 0, 0, 2'b01, 4'h3, 1, 0);
    add(0, 4'h0, 1, 0, 2'b10, 4'h3, 1, 0);
    add(0, 4'h0, 0, 0, 2'b00, 4'h0, 2, 0);
    add(1, 4'hD, 0, 0, 2'b01, 4'hD, 2, 0);
    add(0, 4'h0, 1, 0, 2'b10, 4'hD, 2, 0);
    add(0, 4'h0, 0, 0, 2'b10, 4'hD, 0, 0);
    for (int i = 0; i < 15; i++) add(0, 4'h0, 0, 0, 2'b10, 4'hD, 0, 0);
    add(0, 4'h0, 0, 0, 2'b00, 4'h0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    push_exp(2'b00, 4'h0, 0, 0);
    check("reset");
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].kv, tbl[i].kc, tbl[i].ke, tbl[i].kcl, tbl[i].st, tbl[i].ps, tbl[i].fc, tbl[i].lo,
          $sformatf("vec%0d", i));

    // reset in the middle of OPEN takes effect without a clock edge
    cyc(1, 4'hD, 0, 0, 2'b01, 4'hD, 0, 0, "open_entry");
    cyc(0, 4'h0, 1, 0, 2'b10, 4'hD, 0, 0, "open_check");
    for (int i = 0; i < 5; i++) cyc(0, 4'h0, 0, 0, 2'b10, 4'hD, 0, 0, "open_hold");
    rst = 1'b1;
    #1;
    push_exp(2'b00, 4'h0, 0, 0);
    check("rst_mid_open");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 4'h0, 0, 0, 2'b00, 4'h0, 0, 0, "after_rst");

    // reset clears a nonzero fail count mid-entry
    cyc(1, 4'h3, 0, 0, 2'b01, 4'h3, 0, 0, "pre_fail_entry");
    cyc(0, 4'h0, 1, 0, 2'b10, 4'h3, 0, 0, "pre_fail_check");
    cyc(0, 4'h0, 0, 0, 2'b00, 4'h0, 1, 0, "pre_fail_done");
    cyc(1, 4'h4, 0, 0, 2'b01, 4'h4, 1, 0, "entry_before_rst");
    rst = 1'b1;
    #1;
    push_exp(2'b00, 4'h0, 0, 0);
    check("rst_mid_entry");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // door_open outside CHECK has no effect
    cyc(1, 4'h2, 0, 0, 2'b01, 4'h2, 0, 0, "force_entry");
    door_force = 1'b1;
    cyc(0, 4'h0, 0, 0, 2'b01, 4'h2, 0, 0, "door_open_in_entry");
    door_force = 1'b0;
    cyc(0, 4'h0, 0, 1, 2'b00, 4'h0, 0, 0, "force_clear");

    // inactivity in ENTRY
    cyc(1, 4'h7, 0, 0, 2'b01, 4'h7, 0, 0, "tmo_entry");
    for (int i = 0; i < 31; i++) cyc(0, 4'h0, 0, 0, 2'b01, 4'h7, 0, 0, "tmo_wait");
`ifdef DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN
    cyc(0, 4'h0, 0, 0, 2'b00, 4'h0, 0, 0, "tmo_expire");
`else
    cyc(0, 4'h0, 0, 0, 2'b01, 4'h7, 0, 0, "tmo_none");
    for (int i = 0; i < 8; i++) cyc(0, 4'h0, 0, 0, 2'b01, 4'h7, 0, 0, "tmo_none_hold");
    cyc(0, 4'h0, 0, 1, 2'b00, 4'h0, 0, 0, "tmo_none_clear");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/doorlock_keypad_ctrl.md
Name: doorlock_keypad_ctrl

Overview:
Keypad-side sequencer that drives the door-lock comparator's `state` and `ps_num` inputs and reads back its `door_open` result.
- Captures one 4-bit keypad digit, then commands a check.
- Holds the lock open for a fixed time.
- Counts failed attempts and enters a timed lockout.
- Sits between the keypad scanner (pulsed key events) and the lock comparator.

Parameters:
OPEN_CYCLES, 16, cycles the CHECK code is held after a successful check (door-open hold time)
MAX_FAIL, 3, consecutive failed checks that trigger lockout (1..15)
LOCKOUT_CYCLES, 64, cycles spent in LOCKOUT before returning to IDLE
ENTRY_TIMEOUT, 32, inactivity limit in ENTRY; used only with the optional feature

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle pulse: key_code holds a digit
key_code  input  4  digit value, 0..15
key_enter  input  1  one-cycle pulse: submit entered digit
key_clear  input  1  one-cycle pulse: discard entry
door_open  input  1  comparator result, valid while state=2'b10
state  output  2  command to lock: 00 idle, 01 entry, 10 check, 11 lockout
ps_num  output  4  registered digit presented to lock
fail_cnt  output  4  consecutive failed checks
locked_out  output  1  high while in LOCKOUT

Behaviour:
- Reset, asynchronous: state=00, ps_num=0, fail_cnt=0, locked_out=0, all timers 0, FSM=IDLE. Reset asserted mid-operation aborts any phase immediately.
- All outputs are registered. Each FSM transition is visible on `state` the cycle after the causing input.
- Input priority when several pulses coincide: key_clear > key_enter > key_valid.

FSM states:
- IDLE (00):
  - key_valid -> ps_num<=key_code, go ENTRY.
  - key_enter or key_clear -> ignored.
- ENTRY (01):
  - key_valid -> ps_num<=key_code; the last digit wins.
  - key_enter -> go CHECK.
  - key_clear -> ps_num<=0, go IDLE.
- CHECK (10): one cycle.
  - door_open sampled at the end of that cycle.
  - door_open=1 -> fail_cnt<=0, load hold timer with OPEN_CYCLES-1, go OPEN.
  - door_open=0 -> fail_cnt<=fail_cnt+1.
    - If the new count equals MAX_FAIL -> go LOCKOUT.
    - Otherwise -> ps_num<=0, go IDLE.
- OPEN (still drives 10): hold timer decrements each cycle.
  - Timer reaches 0 -> ps_num<=0, go IDLE.
  - Total time at state=10 is 1+OPEN_CYCLES cycles.
  - Key inputs are ignored.
- LOCKOUT (11): locked_out=1, ps_num=0, all keys ignored.
  - After LOCKOUT_CYCLES cycles -> fail_cnt<=0, locked_out<=0, go IDLE.

Width and boundary rules:
- fail_cnt saturates at 15 and never wraps.
- Timers are sized to $clog2 of their parameter +1.
- door_open is ignored outside CHECK.
- key_valid in the same cycle as the CHECK exit is dropped.

Optional Feature:
DOORLOCK_KEYPAD_CTRL_TIMEOUT_EN
- Defined:
  - ENTRY has an inactivity counter, cleared on every key_valid.
  - Reaching ENTRY_TIMEOUT cycles with no key event -> ps_num<=0, go IDLE.
  - fail_cnt is unchanged.
- Undefined: ENTRY waits indefinitely. No counter logic is synthesized.

Test Plan:
1. Correct entry: rst, key_valid code=4'hD, then key_enter. Model lock opens on D.
   -> state goes 00, 01, then 10 for 17 cycles (OPEN_CYCLES=16), then 00; ps_num=D during check; fail_cnt=0.
2. Wrong entry: code=4'h3, then enter.
   -> state 10 for 1 cycle, then 00; fail_cnt=1; ps_num=0.
3. Three wrong entries in a row (MAX_FAIL=3).
   -> after third check state=11, locked_out=1 for 64 cycles, then state=00, fail_cnt=0; keys pressed during lockout have no effect.
4. Clear and overwrite: key_valid 5, key_valid D, enter.
   -> checks D. In a separate run, key_valid 5 then key_clear -> state 00, ps_num 0. key_clear and key_enter in the same cycle -> clear wins.
5. Reset mid-OPEN: assert rst at cycle 5 of OPEN.
   -> state=00, ps_num=0 asynchronously. Also, a fail followed by a success resets fail_cnt from 2 to 0.
6. Timeout (macro defined, ENTRY_TIMEOUT=32): key_valid 7, then idle.
   -> returns to state 00 after 32 idle cycles. Without the macro it stays at 01.
